// File: rtl/flags_sequencer_pkg.sv
// Shared definitions for the flags sequencer: flag bit positions, condition
// codes, carry-source selects and the branch-wait FSM encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
// Optional feature macro used by the slice: FLAGS_SHADOW_EN (interrupt flag shadow).
package flags_sequencer_pkg;

    // Bit positions inside the architectural {V,S,Z,C} vector.
    localparam int F_C = 0;
    localparam int F_Z = 1;
    localparam int F_S = 2;
    localparam int F_V = 3;

    // Condition-code selectors.
    localparam logic [3:0] COND_AL = 4'd0;   // always
    localparam logic [3:0] COND_EQ = 4'd1;   // Z
    localparam logic [3:0] COND_NE = 4'd2;   // ~Z
    localparam logic [3:0] COND_CS = 4'd3;   // C
    localparam logic [3:0] COND_CC = 4'd4;   // ~C
    localparam logic [3:0] COND_MI = 4'd5;   // S
    localparam logic [3:0] COND_PL = 4'd6;   // ~S
    localparam logic [3:0] COND_VS = 4'd7;   // V
    localparam logic [3:0] COND_VC = 4'd8;   // ~V
    localparam logic [3:0] COND_HI = 4'd9;   // C & ~Z
    localparam logic [3:0] COND_LS = 4'd10;  // ~C | Z
    localparam logic [3:0] COND_GE = 4'd11;  // S == V
    localparam logic [3:0] COND_LT = 4'd12;  // S != V
    localparam logic [3:0] COND_GT = 4'd13;  // ~Z & (S == V)
    localparam logic [3:0] COND_LE = 4'd14;  // Z | (S != V)
    localparam logic [3:0] COND_NV = 4'd15;  // never

    // Carry source, indexed by {CarrySelB, CarrySelA}.
    localparam logic [1:0] CSEL_KEEP  = 2'b00;
    localparam logic [1:0] CSEL_ARITH = 2'b01;
    localparam logic [1:0] CSEL_LOGIC = 2'b10;
    localparam logic [1:0] CSEL_ZERO  = 2'b11;

    // Branch-condition FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EVAL = 2'd2
    } state_t;

    // Candidate carry for a flags update given the delayed select pair.
    function automatic logic carry_pick(input logic [1:0] sel,
                                        input logic       c_old,
                                        input logic       arith_c,
                                        input logic       logic_c);
        logic c_new;
        case (sel)
            CSEL_KEEP:  c_new = c_old;
            CSEL_ARITH: c_new = arith_c;
            CSEL_LOGIC: c_new = logic_c;
            default:    c_new = 1'b0;
        endcase
        return c_new;
    endfunction

endpackage

// File: rtl/flags_sequencer_cond_eval.sv
// Purpose: combinational evaluation of a 4-bit condition code against {V,S,Z,C}.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is sampled.
// Ports: cond_code (selector), flags ({V,S,Z,C}), taken (condition result).
module flags_sequencer_cond_eval
    import flags_sequencer_pkg::*;
(
    input  logic [3:0] cond_code,
    input  logic [3:0] flags,
    output logic       taken
);

    logic v;
    logic s;
    logic z;
    logic c;

    assign v = flags[F_V];
    assign s = flags[F_S];
    assign z = flags[F_Z];
    assign c = flags[F_C];

    always_comb begin
        taken = 1'b0;
        case (cond_code)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = s;
            COND_PL: taken = ~s;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = (s == v);
            COND_LT: taken = (s != v);
            COND_GT: taken = ~z & (s == v);
            COND_LE: taken = z | (s != v);
            default: taken = 1'b0;           // COND_NV
        endcase
    end

endmodule

// File: rtl/flags_sequencer.sv
// Purpose: architectural {V,S,Z,C} register with masked updates, in-flight
//          flag-writer scoreboard and stalled conditional-branch evaluation.
// Latency: flags visible the cycle after ExecValid; CondDone at best one cycle
//          after CondValid, later while flag writers are outstanding.
// Backpressure: IssueStall holds issue when the writer counter is full;
//          CondStall holds the branch requester until CondDone.
// Optional feature: define FLAGS_SHADOW_EN to add an interrupt flag shadow
//          (IntEntry saves, IntReturn restores); otherwise both inputs are ignored.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   IssueFlagWr / IssueStall        flag-writer issue and its hold-off
//   ExecValid, ExecMask             registered ALU flags valid, per-flag enables
//   ArithCarryIn, LogicCarryIn      carry candidates, chosen by CarrySelB/CarrySelA
//   ZeroIn                          zero flag, one cycle ahead of the others
//   SignIn, OverflowIn              registered sign / overflow
//   CondValid, CondCode             branch condition request (held until CondDone)
//   CondStall, CondDone, CondTaken  request status and result
//   Flush                           drops outstanding writers and any pending request
//   IntEntry, IntReturn             shadow save / restore
//   FlagsOut                        architectural {V,S,Z,C}
module flags_sequencer
    import flags_sequencer_pkg::*;
#(
    parameter int         PEND_W      = 2,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       IssueFlagWr,
    output logic       IssueStall,
    input  logic       ExecValid,
    input  logic [3:0] ExecMask,
    input  logic       ArithCarryIn,
    input  logic       LogicCarryIn,
    input  logic       ZeroIn,
    input  logic       SignIn,
    input  logic       OverflowIn,
    input  logic       CarrySelA,
    input  logic       CarrySelB,
    input  logic       CondValid,
    input  logic [3:0] CondCode,
    output logic       CondStall,
    output logic       CondDone,
    output logic       CondTaken,
    input  logic       Flush,
    input  logic       IntEntry,
    input  logic       IntReturn,
    output logic [3:0] FlagsOut
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [3:0]        flags_q;
    logic [3:0]        flags_next;
    logic              zero_d;
    logic              carry_new;
    logic [PEND_W-1:0] pend;
    logic              exec_wr;
    logic              settled;
    logic              cond_hit;
    state_t            state;
    logic              done_q;
    logic              taken_q;

    // ------------------------------------------------------------------
    // Flags register
    // ------------------------------------------------------------------

    // ZeroIn arrives a cycle before the rest of the ALU flags; delaying it
    // here lines it up with the registered V/S/C inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_d <= 1'b0;
        end else begin
            zero_d <= ZeroIn;
        end
    end

    assign carry_new = carry_pick({CarrySelB, CarrySelA}, flags_q[F_C],
                                  ArithCarryIn, LogicCarryIn);

`ifdef FLAGS_SHADOW_EN
    logic [3:0] shadow_q;

    // Captures the value before any same-cycle update, i.e. the flags the
    // interrupted instruction stream actually saw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= RESET_FLAGS;
        end else if (IntEntry) begin
            shadow_q <= flags_q;
        end
    end
`else
    logic unused_int;
    assign unused_int = IntEntry | IntReturn;
`endif

    always_comb begin
        flags_next = flags_q;
        if (ExecValid) begin
            if (ExecMask[F_C]) flags_next[F_C] = carry_new;
            if (ExecMask[F_Z]) flags_next[F_Z] = zero_d;
            if (ExecMask[F_S]) flags_next[F_S] = SignIn;
            if (ExecMask[F_V]) flags_next[F_V] = OverflowIn;
        end
`ifdef FLAGS_SHADOW_EN
        // Returning from the handler wins over any ALU update in flight.
        if (IntReturn) flags_next = shadow_q;
`endif
    end

    // Flush does not touch the flags: an ExecValid in the flush cycle still
    // belongs to an instruction that already completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= RESET_FLAGS;
        end else begin
            flags_q <= flags_next;
        end
    end

    assign FlagsOut = flags_q;

    // ------------------------------------------------------------------
    // In-flight flag-writer scoreboard
    // ------------------------------------------------------------------

    // Only an update that actually writes a flag retires a writer.
    assign exec_wr    = ExecValid & (|ExecMask);
    assign IssueStall = (pend == PEND_MAX);

    // A writer retiring in the same cycle as an issue hands its slot straight
    // to the issuing instruction, so the count holds even at saturation.
    // Issue alone is refused while full and retire alone is refused at zero,
    // so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (Flush) begin
            pend <= '0;
        end else if (IssueFlagWr && exec_wr) begin
            pend <= pend;
        end else if (IssueFlagWr && !IssueStall) begin
            pend <= pend + 1'b1;
        end else if (exec_wr && (pend != '0)) begin
            pend <= pend - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Branch-condition sequencing
    // ------------------------------------------------------------------

    // Flags are final only when no writer is outstanding and the register is
    // not being written this very cycle.
    assign settled = (pend == '0) & ~ExecValid;

    flags_sequencer_cond_eval u_cond_eval (
        .cond_code (CondCode),
        .flags     (flags_q),
        .taken     (cond_hit)
    );

    // done_q is set on the edge that enters EVAL, so it is high exactly for
    // the EVAL cycle; the condition is sampled from the settled flags then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            done_q  <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (Flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (CondValid) begin
                            if (settled) begin
                                state   <= ST_EVAL;
                                done_q  <= 1'b1;
                                taken_q <= cond_hit;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (!CondValid) begin
                            state <= ST_IDLE;
                        end else if (settled) begin
                            state   <= ST_EVAL;
                            done_q  <= 1'b1;
                            taken_q <= cond_hit;
                        end
                    end
                    ST_EVAL: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // A flush landing on the EVAL cycle cancels the result; the held request
    // is then re-evaluated from IDLE.
    assign CondDone  = done_q & ~Flush;
    assign CondTaken = taken_q;
    assign CondStall = CondValid & (state != ST_EVAL);

endmodule

// File: tb/tb_flags_sequencer.sv
module tb_flags_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       IssueFlagWr;
    logic       IssueStall;
    logic       ExecValid;
    logic [3:0] ExecMask;
    logic       ArithCarryIn;
    logic       LogicCarryIn;
    logic       ZeroIn;
    logic       SignIn;
    logic       OverflowIn;
    logic       CarrySelA;
    logic       CarrySelB;
    logic       CondValid;
    logic [3:0] CondCode;
    logic       CondStall;
    logic       CondDone;
    logic       CondTaken;
    logic       Flush;
    logic       IntEntry;
    logic       IntReturn;
    logic [3:0] FlagsOut;

    int checks = 0;
    int errors = 0;

    localparam int PMAX = 3;

    flags_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IssueFlagWr  (IssueFlagWr),
        .IssueStall   (IssueStall),
        .ExecValid    (ExecValid),
        .ExecMask     (ExecMask),
        .ArithCarryIn (ArithCarryIn),
        .LogicCarryIn (LogicCarryIn),
        .ZeroIn       (ZeroIn),
        .SignIn       (SignIn),
        .OverflowIn   (OverflowIn),
        .CarrySelA    (CarrySelA),
        .CarrySelB    (CarrySelB),
        .CondValid    (CondValid),
        .CondCode     (CondCode),
        .CondStall    (CondStall),
        .CondDone     (CondDone),
        .CondTaken    (CondTaken),
        .Flush        (Flush),
        .IntEntry     (IntEntry),
        .IntReturn    (IntReturn),
        .FlagsOut     (FlagsOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] flags;   // {V,S,Z,C}
        logic       taken;
    } cond_vec_t;

    cond_vec_t tbl [22];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        IssueFlagWr  = 1'b0;
        ExecValid    = 1'b0;
        ExecMask     = 4'b0000;
        ArithCarryIn = 1'b0;
        LogicCarryIn = 1'b0;
        ZeroIn       = 1'b0;
        SignIn       = 1'b0;
        OverflowIn   = 1'b0;
        CarrySelA    = 1'b0;
        CarrySelB    = 1'b0;
        CondValid    = 1'b0;
        CondCode     = 4'd0;
        Flush        = 1'b0;
        IntEntry     = 1'b0;
        IntReturn    = 1'b0;
    endtask

    // Writes all four flags to f; f is visible from the cycle this returns in.
    task automatic load_flags(input logic [3:0] f);
        ZeroIn = f[1];
        cyc();
        ZeroIn       = 1'b0;
        ExecValid    = 1'b1;
        ExecMask     = 4'hF;
        CarrySelA    = 1'b1;
        CarrySelB    = 1'b0;
        ArithCarryIn = f[0];
        SignIn       = f[2];
        OverflowIn   = f[3];
        cyc();
        idle_in();
    endtask

    // Reference condition: codes 1..14 are seven base predicates, odd codes
    // taking the predicate and even codes its complement.
    function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
        logic v, s, z, c;
        logic [6:0] p;
        int k;
        v = f[3]; s = f[2]; z = f[1]; c = f[0];
        p = {~z & (s == v), s == v, c & ~z, v, s, c, z};
        if (code == 4'd0)  return 1'b1;
        if (code == 4'd15) return 1'b0;
        k = (int'(code) - 1) / 2;
        return code[0] ? p[k] : ~p[k];
    endfunction

    // Random-phase reference state.
    logic [3:0] m_flags, m_shadow, n_flags;
    logic       m_zd, m_done, m_taken, n_done, n_taken, last_done, exp_done, exec_dec;
    int         m_pend, n_pend;

    initial begin
        tbl[0]  = '{4'd0,  4'b0000, 1'b1};
        tbl[1]  = '{4'd1,  4'b0010, 1'b1};
        tbl[2]  = '{4'd1,  4'b0000, 1'b0};
        tbl[3]  = '{4'd2,  4'b0010, 1'b0};
        tbl[4]  = '{4'd3,  4'b0001, 1'b1};
        tbl[5]  = '{4'd4,  4'b0001, 1'b0};
        tbl[6]  = '{4'd5,  4'b0100, 1'b1};
        tbl[7]  = '{4'd6,  4'b0100, 1'b0};
        tbl[8]  = '{4'd7,  4'b1000, 1'b1};
        tbl[9]  = '{4'd8,  4'b0000, 1'b1};
        tbl[10] = '{4'd9,  4'b0001, 1'b1};
        tbl[11] = '{4'd9,  4'b0011, 1'b0};
        tbl[12] = '{4'd10, 4'b0011, 1'b1};
        tbl[13] = '{4'd10, 4'b0001, 1'b0};
        tbl[14] = '{4'd11, 4'b1100, 1'b1};
        tbl[15] = '{4'd11, 4'b0100, 1'b0};
        tbl[16] = '{4'd12, 4'b1000, 1'b1};
        tbl[17] = '{4'd13, 4'b0000, 1'b1};
        tbl[18] = '{4'd13, 4'b0010, 1'b0};
        tbl[19] = '{4'd14, 4'b0010, 1'b1};
        tbl[20] = '{4'd14, 4'b0000, 1'b0};
        tbl[21] = '{4'd15, 4'b1111, 1'b0};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle_in();
        @(negedge clk);
        chk4("rst_flags", FlagsOut, 4'b0000);
        chk1("rst_istall", IssueStall, 1'b0);
        chk1("rst_cstall", CondStall, 1'b0);
        chk1("rst_done", CondDone, 1'b0);
        chk1("rst_taken", CondTaken, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---------------- condition table ----------------
        for (int i = 0; i < 22; i++) begin
            load_flags(tbl[i].flags);
            CondValid = 1'b1;
            CondCode  = tbl[i].code;
            @(negedge clk);
            chk4("tbl_flags", FlagsOut, tbl[i].flags);
            chk1("tbl_stall", CondStall, 1'b1);
            cyc();
            @(negedge clk);
            chk1("tbl_done", CondDone, 1'b1);
            chk1("tbl_taken", CondTaken, tbl[i].taken);
            cyc();
            CondValid = 1'b0;
        end

        // ---------------- masked update with zero alignment ----------------
        load_flags(4'b0000);
        ZeroIn = 1'b1; SignIn = 1'b1; OverflowIn = 1'b1;
        cyc();
        ZeroIn = 1'b0; ExecValid = 1'b1; ExecMask = 4'b0011;
        CarrySelA = 1'b1; CarrySelB = 1'b0; ArithCarryIn = 1'b1;
        cyc();
        idle_in();
        @(negedge clk);
        chk4("upd_mask", FlagsOut, 4'b0011);

        // Carry source sweep: {selB,selA}, arith, logic -> expected flags.
        begin
            logic [1:0] sel [5];
            logic       ac  [5];
            logic       lc  [5];
            logic [3:0] ex  [5];
            sel[0] = 2'b10; ac[0] = 1'b1; lc[0] = 1'b0; ex[0] = 4'b0010;
            sel[1] = 2'b01; ac[1] = 1'b1; lc[1] = 1'b0; ex[1] = 4'b0011;
            sel[2] = 2'b00; ac[2] = 1'b0; lc[2] = 1'b0; ex[2] = 4'b0011;
            sel[3] = 2'b11; ac[3] = 1'b1; lc[3] = 1'b1; ex[3] = 4'b0010;
            sel[4] = 2'b10; ac[4] = 1'b0; lc[4] = 1'b1; ex[4] = 4'b0011;
            for (int i = 0; i < 5; i++) begin
                ExecValid = 1'b1; ExecMask = 4'b0001;
                CarrySelB = sel[i][1]; CarrySelA = sel[i][0];
                ArithCarryIn = ac[i]; LogicCarryIn = lc[i];
                cyc();
                idle_in();
                @(negedge clk);
                chk4("carry_sel", FlagsOut, ex[i]);
                cyc();
            end
        end

        // ---------------- hazard: writer outstanding ----------------
        IssueFlagWr = 1'b1;                          // N
        cyc();
        IssueFlagWr = 1'b0; CondValid = 1'b1; CondCode = 4'd2;   // N+1
        @(negedge clk);
        chk1("haz_stall1", CondStall, 1'b1);
        chk1("haz_done1", CondDone, 1'b0);
        cyc();                                       // N+2
        @(negedge clk);
        chk1("haz_stall2", CondStall, 1'b1);
        chk1("haz_done2", CondDone, 1'b0);
        cyc();                                       // N+3: writer completes, clears Z
        ExecValid = 1'b1; ExecMask = 4'b0010;
        @(negedge clk);
        chk1("haz_stall3", CondStall, 1'b1);
        chk1("haz_done3", CondDone, 1'b0);
        cyc();                                       // N+4
        ExecValid = 1'b0; ExecMask = 4'b0000;
        @(negedge clk);
        chk1("haz_stall4", CondStall, 1'b1);
        chk1("haz_done4", CondDone, 1'b0);
        cyc();                                       // N+5
        @(negedge clk);
        chk1("haz_done5", CondDone, 1'b1);
        chk1("haz_taken", CondTaken, 1'b1);
        chk1("haz_stall5", CondStall, 1'b0);
        chk4("haz_flags", FlagsOut, 4'b0001);
        cyc();
        CondValid = 1'b0;
        @(negedge clk);
        chk1("haz_done6", CondDone, 1'b0);

        // ---------------- counter saturation ----------------
        cyc();
        IssueFlagWr = 1'b1;
        @(negedge clk); chk1("sat_p0", IssueStall, 1'b0);
        cyc(); @(negedge clk); chk1("sat_p1", IssueStall, 1'b0);
        cyc(); @(negedge clk); chk1("sat_p2", IssueStall, 1'b0);
        cyc(); @(negedge clk); chk1("sat_p3", IssueStall, 1'b1);
        cyc();                                       // 4th issue was refused
        ExecValid = 1'b1; ExecMask = 4'b0001; CarrySelA = 1'b0; CarrySelB = 1'b0;
        @(negedge clk); chk1("sat_4th", IssueStall, 1'b1);
        cyc();                                       // issue + retire together
        IssueFlagWr = 1'b0;
        @(negedge clk); chk1("sat_both", IssueStall, 1'b1);
        cyc(); @(negedge clk); chk1("sat_dec", IssueStall, 1'b0);
        cyc();
        cyc();
        cyc();                                       // retire at zero ignored
        ExecValid = 1'b0; ExecMask = 4'b0000; CondValid = 1'b1; CondCode = 4'd0;
        @(negedge clk); chk1("sat_nowrap", IssueStall, 1'b0);
        cyc(); @(negedge clk); chk1("sat_zero_done", CondDone, 1'b1);
        cyc();
        CondValid = 1'b0;

        // ---------------- flush while waiting ----------------
        IssueFlagWr = 1'b1;
        cyc();
        cyc();
        IssueFlagWr = 1'b0; CondValid = 1'b1; CondCode = 4'd3;
        @(negedge clk); chk1("fl_stall", CondStall, 1'b1);
        cyc();
        Flush = 1'b1;
        @(negedge clk); chk1("fl_done0", CondDone, 1'b0);
        cyc();
        Flush = 1'b0;
        @(negedge clk);
        chk1("fl_done1", CondDone, 1'b0);
        chk1("fl_stall1", CondStall, 1'b1);
        cyc();
        @(negedge clk);
        chk1("fl_done2", CondDone, 1'b1);
        chk1("fl_taken", CondTaken, 1'b1);
        cyc();
        CondValid = 1'b0;

        // ---------------- flush on the EVAL cycle ----------------
        cyc();
        CondValid = 1'b1; CondCode = 4'd0;
        cyc();
        Flush = 1'b1;
        @(negedge clk); chk1("fe_suppress", CondDone, 1'b0);
        cyc();
        Flush = 1'b0;
        @(negedge clk); chk1("fe_idle", CondDone, 1'b0);
        cyc();
        @(negedge clk); chk1("fe_redo", CondDone, 1'b1);
        cyc();
        CondValid = 1'b0;

        // ---------------- reset in the middle of a wait ----------------
        IssueFlagWr = 1'b1;
        cyc();
        IssueFlagWr = 1'b0; CondValid = 1'b1; CondCode = 4'd0;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk4("rw_flags", FlagsOut, 4'b0000);
        chk1("rw_istall", IssueStall, 1'b0);
        chk1("rw_done", CondDone, 1'b0);
        chk1("rw_stall", CondStall, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("rw_stall2", CondStall, 1'b1);
        chk1("rw_done2", CondDone, 1'b0);
        cyc();
        @(negedge clk);
        chk1("rw_done3", CondDone, 1'b1);
        cyc();
        CondValid = 1'b0;

        // ---------------- shadow save / restore ----------------
        load_flags(4'b1010);
        IntEntry = 1'b1;
        cyc();
        IntEntry = 1'b0;
        load_flags(4'b0101);
        @(negedge clk); chk4("sh_new", FlagsOut, 4'b0101);
        IntReturn = 1'b1; ExecValid = 1'b1; ExecMask = 4'hF;
        CarrySelA = 1'b1; ArithCarryIn = 1'b1; SignIn = 1'b1; OverflowIn = 1'b1;
        cyc();
        idle_in();
        @(negedge clk);
`ifdef FLAGS_SHADOW_EN
        chk4("sh_restore", FlagsOut, 4'b1010);
`else
        chk4("sh_ignored", FlagsOut, 4'b1101);
`endif

        // ---------------- randomized run against reference ----------------
        cyc();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        m_flags = 4'b0000; m_shadow = 4'b0000; m_zd = 1'b0;
        m_pend = 0; m_done = 1'b0; m_taken = 1'b0; last_done = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (!CondValid || last_done) begin
                CondValid = ($urandom_range(0, 3) == 0);
                CondCode  = 4'($urandom_range(0, 15));
            end
            IssueFlagWr  = ($urandom_range(0, 2) == 0);
            ExecValid    = ($urandom_range(0, 2) == 0);
            ExecMask     = 4'($urandom_range(0, 15));
            ArithCarryIn = 1'($urandom_range(0, 1));
            LogicCarryIn = 1'($urandom_range(0, 1));
            ZeroIn       = 1'($urandom_range(0, 1));
            SignIn       = 1'($urandom_range(0, 1));
            OverflowIn   = 1'($urandom_range(0, 1));
            CarrySelA    = 1'($urandom_range(0, 1));
            CarrySelB    = 1'($urandom_range(0, 1));
            Flush        = ($urandom_range(0, 31) == 0);
            IntEntry     = ($urandom_range(0, 15) == 0);
            IntReturn    = ($urandom_range(0, 15) == 0);

            @(negedge clk);
            exp_done = m_done & ~Flush;
            chk4("rnd_flags", FlagsOut, m_flags);
            chk1("rnd_istall", IssueStall, m_pend == PMAX);
            chk1("rnd_cstall", CondStall, CondValid & ~m_done);
            chk1("rnd_done", CondDone, exp_done);
            if (exp_done) chk1("rnd_taken", CondTaken, m_taken);
            last_done = exp_done;

            // Next flags
            n_flags = m_flags;
            if (ExecValid) begin
                if (ExecMask[0]) begin
                    case ({CarrySelB, CarrySelA})
                        2'b01:   n_flags[0] = ArithCarryIn;
                        2'b10:   n_flags[0] = LogicCarryIn;
                        2'b11:   n_flags[0] = 1'b0;
                        default: n_flags[0] = m_flags[0];
                    endcase
                end
                if (ExecMask[1]) n_flags[1] = m_zd;
                if (ExecMask[2]) n_flags[2] = SignIn;
                if (ExecMask[3]) n_flags[3] = OverflowIn;
            end
`ifdef FLAGS_SHADOW_EN
            if (IntReturn) n_flags = m_shadow;
`endif
            // Next writer count
            exec_dec = ExecValid && (ExecMask != 4'b0000);
            n_pend = m_pend;
            if (Flush)                            n_pend = 0;
            else if (IssueFlagWr && exec_dec)     n_pend = m_pend;
            else if (IssueFlagWr && m_pend < PMAX) n_pend = m_pend + 1;
            else if (exec_dec && m_pend > 0)      n_pend = m_pend - 1;
            // Next condition result: one-cycle pulse once flags are settled
            n_done  = 1'b0;
            n_taken = m_taken;
            if (!Flush && !m_done && CondValid && m_pend == 0 && !ExecValid) begin
                n_done  = 1'b1;
                n_taken = ref_cond(CondCode, m_flags);
            end

            @(posedge clk);
            #1;
`ifdef FLAGS_SHADOW_EN
            if (IntEntry) m_shadow = m_flags;
`endif
            m_flags = n_flags;
            m_zd    = ZeroIn;
            m_pend  = n_pend;
            m_done  = n_done;
            m_taken = n_taken;
        end

        idle_in();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
